// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared control bundle, opcodes and instruction field positions.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    typedef struct packed {
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] alu_op;
        logic       branch;
    } ctrl_t;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BR     = 7'b1100011;

    localparam int REG_IDX_W  = 5;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNCT7_B5  = 30;

endpackage
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Load-use hazard detection between EX and ID; a flush masks it.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
    import riscv_pkg::*;
(
    input  logic                 i_ex_valid,
    input  logic                 i_ex_mem_read,
    input  logic [REG_IDX_W-1:0] i_ex_rd,
    input  logic                 i_id_valid,
    input  logic [REG_IDX_W-1:0] i_id_rs1,
    input  logic [REG_IDX_W-1:0] i_id_rs2,
    input  logic                 i_id_alu_src,
    input  logic                 i_id_mem_write,
    input  logic                 i_flush,
    output logic                 o_stall
);

    logic w_load_in_ex;
    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_load_in_ex = i_ex_valid & i_ex_mem_read & (i_ex_rd != '0);
    assign w_rs1_hit    = (i_ex_rd == i_id_rs1);
    // rs2 only matters when it is really read: register ALU operand or store data
    assign w_rs2_hit    = (i_ex_rd == i_id_rs2) & (~i_id_alu_src | i_id_mem_write);

    assign o_stall = w_load_in_ex & i_id_valid & (w_rs1_hit | w_rs2_hit) & ~i_flush;

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with load-use bubble insertion,
//               flush squash and a saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [31:0]       id_instr,
    input  logic [PC_W-1:0]   id_pc,
    input  ctrl_t             id_ctrl,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output ctrl_t             ex_ctrl,
    output logic [PC_W-1:0]   ex_pc,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [3:0]        ex_funct,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [REG_IDX_W-1:0] w_rs1;
    logic [REG_IDX_W-1:0] w_rs2;
    logic [REG_IDX_W-1:0] w_rd;
    logic [3:0]           w_funct;
    logic                 w_stall;
    logic                 w_take;
    logic                 w_unused_instr_bits;

    logic                 r_valid;
    ctrl_t                r_ctrl;
    logic [PC_W-1:0]      r_pc;
    logic [DATA_W-1:0]    r_rd1;
    logic [DATA_W-1:0]    r_rd2;
    logic [DATA_W-1:0]    r_imm;
    logic [4:0]           r_rs1;
    logic [4:0]           r_rs2;
    logic [4:0]           r_rd;
    logic [3:0]           r_funct;
    logic [CNT_W-1:0]     r_stall_cnt;

    assign w_rs1   = id_instr[RS1_LSB +: REG_IDX_W];
    assign w_rs2   = id_instr[RS2_LSB +: REG_IDX_W];
    assign w_rd    = id_instr[RD_LSB +: REG_IDX_W];
    assign w_funct = {id_instr[FUNCT7_B5], id_instr[FUNCT3_LSB +: 3]};
    assign w_unused_instr_bits = ^{id_instr[31], id_instr[29:25], id_instr[6:0]};

    hazard_unit u_hazard_unit (
        .i_ex_valid     (r_valid),
        .i_ex_mem_read  (r_ctrl.mem_read),
        .i_ex_rd        (r_rd),
        .i_id_valid     (id_valid),
        .i_id_rs1       (w_rs1),
        .i_id_rs2       (w_rs2),
        .i_id_alu_src   (id_ctrl.alu_src),
        .i_id_mem_write (id_ctrl.mem_write),
        .i_flush        (flush),
        .o_stall        (w_stall)
    );

    // Only a live, unsquashed, unstalled instruction carries control into EX
    assign w_take = id_valid & ~flush & ~w_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_ctrl      <= '0;
            r_pc        <= '0;
            r_rd1       <= '0;
            r_rd2       <= '0;
            r_imm       <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_funct     <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_valid <= w_take;
            r_ctrl  <= w_take ? id_ctrl : '0;
            // Data is held across a stall bubble so the EX view stays stable
            if (!w_stall) begin
                r_pc    <= id_pc;
                r_rd1   <= id_rd1;
                r_rd2   <= id_rd2;
                r_imm   <= id_imm;
                r_rs1   <= w_rs1;
                r_rs2   <= w_rs2;
                r_rd    <= w_rd;
                r_funct <= w_funct;
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign stall     = w_stall;
    assign ex_valid  = r_valid;
    assign ex_ctrl   = r_ctrl;
    assign ex_pc     = r_pc;
    assign ex_rd1    = r_rd1;
    assign ex_rd2    = r_rd2;
    assign ex_imm    = r_imm;
    assign ex_rs1    = r_rs1;
    assign ex_rs2    = r_rs2;
    assign ex_rd     = r_rd;
    assign ex_funct  = r_funct;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Scoreboard bench for id_ex_stage with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;
    import riscv_pkg::*;

    localparam int DW = 32;
    localparam int PW = 9;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          id_valid = 1'b0;
    logic [31:0]   id_instr = '0;
    logic [PW-1:0] id_pc = '0;
    ctrl_t         id_ctrl = '0;
    logic [DW-1:0] id_rd1 = '0, id_rd2 = '0, id_imm = '0;
    logic          flush = 1'b0;
    logic          stall, ex_valid;
    ctrl_t         ex_ctrl;
    logic [PW-1:0] ex_pc;
    logic [DW-1:0] ex_rd1, ex_rd2, ex_imm;
    logic [4:0]    ex_rs1, ex_rs2, ex_rd;
    logic [3:0]    ex_funct;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DW), .PC_W(PW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc(id_pc), .id_ctrl(id_ctrl), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_imm(id_imm), .flush(flush), .stall(stall), .ex_valid(ex_valid),
        .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct(ex_funct), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic          valid;
        logic [7:0]    ctrl;
        logic          known;
        logic [PW-1:0] pc;
        logic [DW-1:0] rd1, rd2, imm;
        logic [4:0]    rs1, rs2, rd;
        logic [3:0]    funct;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t m;                // what EX should hold after the most recent edge
    logic m_init = 1'b0;
    logic last_stall = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Control bundle bits: {alu_src, mem_to_reg, reg_write, mem_read, mem_write, alu_op, branch}
    function automatic logic [7:0] ctrl_of(logic [6:0] op);
        case (op)
            R_TYPE:  return 8'b0010_0100;
            I_TYPE:  return 8'b1010_0100;
            LW:      return 8'b1111_0000;
            SW:      return 8'b1000_1000;
            BR:      return 8'b0000_0011;
            default: return 8'b0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] enc(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                                        logic [4:0] rs2, logic [2:0] f3, logic f7b5);
        return {1'b0, f7b5, 5'b0, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [4:0] rreg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd1;
            2:       return 5'd2;
            default: return 5'd5;
        endcase
    endfunction

    // One cycle of stimulus; predicts stall now and the EX contents after the edge
    task automatic drive(input logic [31:0] ins, input logic v, input logic fl, input logic rs);
        logic [7:0] c;
        logic       es, uses_rs2;
        @(negedge clk);
        c = ctrl_of(ins[6:0]);
        if (!v && $urandom_range(0, 1) == 1) c = 8'($urandom);
        id_instr = ins;
        id_ctrl  = ctrl_t'(c);
        id_valid = v;
        flush    = fl;
        reset    = rs;
        id_pc    = PW'($urandom);
        id_rd1   = $urandom;
        id_rd2   = $urandom;
        id_imm   = $urandom;
        uses_rs2 = !c[7] || c[3];
        es = m.valid && m.ctrl[4] && (m.rd != 0) && v && !fl &&
             ((m.rd == ins[19:15]) || (uses_rs2 && m.rd == ins[24:20]));
        #1;
        if (m_init) chk("stall", {63'd0, stall}, {63'd0, es});
        if (rs) begin
            m = '{valid: 1'b0, ctrl: 8'd0, known: 1'b1, pc: '0, rd1: '0, rd2: '0,
                  imm: '0, rs1: '0, rs2: '0, rd: '0, funct: '0, cnt: '0};
            m_init = 1'b1;
            es = 1'b0;
        end else if (es) begin
            m.valid = 1'b0;
            m.ctrl  = 8'd0;
            if (m.cnt != {CW{1'b1}}) m.cnt = m.cnt + 1'b1;
        end else begin
            m.valid = v && !fl;
            m.ctrl  = m.valid ? c : 8'd0;
            m.known = m.valid;
            m.pc    = id_pc;
            m.rd1   = id_rd1;
            m.rd2   = id_rd2;
            m.imm   = id_imm;
            m.rs1   = ins[19:15];
            m.rs2   = ins[24:20];
            m.rd    = ins[11:7];
            m.funct = {ins[30], ins[14:12]};
        end
        last_stall = es;
        q.push_back(m);
    endtask

    // Issue a valid instruction, replaying it while the front end is frozen
    task automatic issue(input logic [31:0] ins, input logic fl);
        int k;
        k = 0;
        drive(ins, 1'b1, fl, 1'b0);
        while (last_stall && k < 4) begin
            drive(ins, 1'b1, 1'b0, 1'b0);
            k++;
        end
        chk("stall_release", {63'd0, last_stall}, 64'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ex_valid", {63'd0, ex_valid}, {63'd0, e.valid});
                chk("ex_ctrl", {56'd0, ex_ctrl}, {56'd0, e.ctrl});
                chk("stall_cnt", {56'd0, stall_cnt}, {56'd0, e.cnt});
                if (e.known) begin
                    chk("ex_pc", {55'd0, ex_pc}, {55'd0, e.pc});
                    chk("ex_rd1", {32'd0, ex_rd1}, {32'd0, e.rd1});
                    chk("ex_rd2", {32'd0, ex_rd2}, {32'd0, e.rd2});
                    chk("ex_imm", {32'd0, ex_imm}, {32'd0, e.imm});
                    chk("ex_idx", {45'd0, ex_rs1, ex_rs2, ex_rd, ex_funct},
                                  {45'd0, e.rs1, e.rs2, e.rd, e.funct});
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] cur;
        logic        cur_v;
        logic [6:0]  ops [5];
        int          k;
        ops[0] = R_TYPE; ops[1] = I_TYPE; ops[2] = LW; ops[3] = SW; ops[4] = BR;
        m = '{valid: 1'b0, ctrl: 8'd0, known: 1'b0, pc: '0, rd1: '0, rd2: '0,
              imm: '0, rs1: '0, rs2: '0, rd: '0, funct: '0, cnt: '0};
        drive(32'd0, 1'b0, 1'b0, 1'b1);
        drive(32'd0, 1'b0, 1'b0, 1'b1);

        // independent ALU ops back to back
        issue(enc(R_TYPE, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0), 1'b0);
        issue(enc(R_TYPE, 5'd4, 5'd1, 5'd5, 3'd0, 1'b1), 1'b0);
        // load-use on rs1: one bubble, counter to 1
        issue(enc(LW, 5'd5, 5'd0, 5'd0, 3'd2, 1'b0), 1'b0);
        issue(enc(R_TYPE, 5'd6, 5'd5, 5'd1, 3'd0, 1'b0), 1'b0);
        chk("lw_use_cnt", {56'd0, stall_cnt}, 64'd1);
        // load to x0 never stalls
        issue(enc(LW, 5'd0, 5'd1, 5'd0, 3'd2, 1'b0), 1'b0);
        issue(enc(R_TYPE, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0), 1'b0);
        // store data hazard vs immediate that only looks like rs2
        issue(enc(LW, 5'd5, 5'd0, 5'd0, 3'd2, 1'b0), 1'b0);
        issue(enc(SW, 5'd4, 5'd2, 5'd5, 3'd2, 1'b0), 1'b0);
        issue(enc(LW, 5'd5, 5'd0, 5'd0, 3'd2, 1'b0), 1'b0);
        issue(enc(I_TYPE, 5'd6, 5'd7, 5'd5, 3'd0, 1'b0), 1'b0);
        chk("rs2_hazard_cnt", {56'd0, stall_cnt}, 64'd2);
        // flush beats the hazard
        issue(enc(LW, 5'd5, 5'd0, 5'd0, 3'd2, 1'b0), 1'b0);
        drive(enc(R_TYPE, 5'd6, 5'd5, 5'd1, 3'd0, 1'b0), 1'b1, 1'b1, 1'b0);
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        chk("flush_cnt", {56'd0, stall_cnt}, 64'd2);

        // randomized traffic; a stalled instruction is held in ID
        cur = '0;
        cur_v = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!last_stall) begin
                cur = enc(ops[$urandom_range(0, 4)], rreg(), rreg(), rreg(),
                          3'($urandom), 1'($urandom));
                cur_v = ($urandom_range(0, 9) != 0);
            end
            drive(cur, cur_v, ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0));
        end

        // saturate the stall counter with a chain of dependent loads
        drive(32'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < (1 << CW) + 4; i++) begin
            issue(enc(LW, 5'd5, 5'd5, 5'd0, 3'd2, 1'b0), 1'b0);
        end
        chk("cnt_sat", {56'd0, stall_cnt}, {56'd0, {CW{1'b1}}});

        // reset while a hazard is pending discards it
        issue(enc(LW, 5'd5, 5'd0, 5'd0, 3'd2, 1'b0), 1'b0);
        drive(enc(R_TYPE, 5'd6, 5'd5, 5'd1, 3'd0, 1'b0), 1'b1, 1'b0, 1'b1);
        drive(enc(R_TYPE, 5'd6, 5'd5, 5'd1, 3'd0, 1'b0), 1'b1, 1'b0, 1'b0);
        drive(32'd0, 1'b0, 1'b0, 1'b0);

        k = 0;
        while (q.size() > 0 && k < 10) begin
            @(posedge clk);
            k++;
        end
        #2;
        chk("drain", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, 32, width of register operands and immediate.
REQ-002 Parameter PC_W, 9, width of the program counter.
REQ-003 Parameter CNT_W, 16, width of the stall statistics counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 id_valid  input  1  decode stage holds a real instruction.
REQ-007 id_instr  input  32  instruction word in decode; rs1=[19:15], rs2=[24:20], rd=[11:7], funct3=[14:12], funct7[5]=[30].
REQ-008 id_pc  input  PC_W  PC of decoded instruction.
REQ-009 id_ctrl  input  ctrl_t  decoded control bundle {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp[1:0], Branch}.
REQ-010 id_rd1 / id_rd2  input  DATA_W each  register file read data.
REQ-011 id_imm  input  DATA_W  sign-extended immediate.
REQ-012 flush  input  1  branch taken in EX; squash the decode instruction.
REQ-013 stall  output  1  load-use hazard; freeze PC and IF/ID register.
REQ-014 ex_valid, ex_ctrl, ex_pc, ex_rd1, ex_rd2, ex_imm  output  registered copies of the id_* fields.
REQ-015 ex_rs1, ex_rs2, ex_rd  output  5 each  registered register indices.
REQ-016 ex_funct  output  4  registered {funct7[5], funct3}.
REQ-017 stall_cnt  output  CNT_W  count of bubbles inserted by stall.

Function
REQ-018 Normal case (no stall, no flush): every ex_* output SHALL equal the id_* value of the previous cycle; latency exactly 1 cycle.
REQ-019 stall SHALL be combinational: ex_valid & ex_ctrl.MemRead & (ex_rd != 0) & id_valid & ((ex_rd == rs1) | (ex_rd == rs2 & ~id_ctrl.ALUSrc | ex_rd == rs2 & id_ctrl.MemWrite)).
REQ-020 On stall, the next cycle SHALL have ex_valid=0 and ex_ctrl all-zero (bubble); data fields are don't-care but SHALL be held.
REQ-021 The stalled instruction SHALL be accepted on the first cycle stall deasserts; it is captured exactly once.
REQ-022 On flush, the next cycle SHALL carry a bubble, and stall SHALL be forced to 0 in that cycle.
REQ-023 flush and stall asserted together: flush wins; one bubble; stall_cnt unchanged.
REQ-024 id_valid=0: captured as bubble (ex_valid=0, ex_ctrl=0) regardless of id_ctrl.
REQ-025 ex_ctrl SHALL be zero whenever ex_valid=0, so no RegWrite/MemWrite leaks downstream.
REQ-026 stall_cnt SHALL increment by 1 per cycle stall is high and saturate at all-ones (no wrap).
REQ-027 rd=x0 as load destination SHALL never cause a stall.

Reset
REQ-028 reset high at a clock edge SHALL set ex_valid=0, ex_ctrl=0, all ex_* data/index fields=0, stall_cnt=0.
REQ-029 stall SHALL read 0 in the cycle after reset (follows from ex_valid=0).
REQ-030 reset during a stall SHALL discard the pending hazard; no instruction is replayed by this block.

Structure
REQ-031 Package riscv_pkg SHALL hold ctrl_t (packed struct), opcode constants (R_TYPE, I_TYPE, LW, SW, BR) and field-position constants.
REQ-032 One sub-module hazard_unit SHALL compute stall combinationally; the pipeline register and counter stay in id_ex_stage.

Verification
REQ-033 Sequential add x1,x2,x3 then add x4,x1,x5 -> no stall; ex_* match id_* with 1-cycle delay.
REQ-034 lw x5,0(x0) then add x6,x5,x1 -> stall=1 one cycle, one bubble (ex_valid=0, ex_ctrl=0), add in EX next cycle, stall_cnt=1.
REQ-035 lw x0,0(x1) then add x2,x0,x0 -> stall=0.
REQ-036 lw x5 then sw x5,4(x2) (rs2 hazard) -> stall=1; lw x5 then addi x6,x7,1 with rs2 field=5 -> stall=0.
REQ-037 lw x5 then add x6,x5,x1 with flush=1 same cycle -> stall=0, bubble, stall_cnt unchanged.
REQ-038 Force stall for 2^CNT_W+3 cycles -> stall_cnt saturates at all-ones; reset mid-run -> all outputs 0 next cycle.
